// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: DECODE -> EXEC [-> MEM] -> retire, with
// return-stack depth tracking, debug halt/resume and memory-ack timeout fault.
module cpu_sequencer #(
  parameter int STACK_DEPTH = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       c_flag,
  input  logic       z_flag,
  input  logic       mem_ack,
  input  logic       halt_req,
  input  logic       resume,
  output logic       pc_en,
  output logic       mem_req,
  output logic       mem_write,
  output logic       reg_write,
  output logic       push,
  output logic       pop,
  output logic [2:0] alu_op,
  output logic [1:0] pc_mux,
  output logic [1:0] reg_write_mux,
  output logic       alu_use_carry,
  output logic       alu_in_mux,
  output logic       reg_B_mux,
  output logic       select_c,
  output logic       select_z,
  output logic       write_c,
  output logic       write_z,
  output logic       halted,
  output logic       fault,
  output logic [3:0] stack_depth
);

  typedef enum logic [2:0] {
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);
  localparam logic [3:0] TMO_LAST  = 4'(ACK_TIMEOUT - 1);

  state_t     state_q;
  logic [4:0] ir_q;
  logic [3:0] tmo_q;
  logic [3:0] depth_q;

  logic is_alu, is_imm, is_shift, is_load, is_store, is_mem, is_branch;
  logic is_jmp, is_jsr, is_ret, is_halt;
  logic br_taken, stk_fault, retire;
  state_t exit_state;

  always_comb begin
    is_alu    = (ir_q[4] == 1'b0);
    is_imm    = (ir_q[4:3] == 2'b01);
    is_shift  = (ir_q[4:2] == 3'b110);
    is_load   = (ir_q == 5'b10000);
    is_store  = (ir_q == 5'b10001);
    is_mem    = is_load | is_store;
    is_branch = (ir_q[4:2] == 3'b101);
    is_jmp    = (ir_q == 5'b11100);
    is_jsr    = (ir_q == 5'b11101);
    is_ret    = (ir_q == 5'b11110);
    is_halt   = (ir_q == 5'b11111);
    case (ir_q[1:0])
      2'b00:   br_taken = z_flag;
      2'b01:   br_taken = ~z_flag;
      2'b10:   br_taken = c_flag;
      default: br_taken = ~c_flag;
    endcase
    // Stack over/underflow is caught in EXEC, before any strobe fires.
    stk_fault  = (is_jsr && depth_q == DEPTH_MAX) || (is_ret && depth_q == 4'd0);
    retire     = reset && ((state_q == S_EXEC && !is_mem && !stk_fault) ||
                           (state_q == S_MEM && mem_ack));
    exit_state = (halt_req || is_halt) ? S_HALTED : S_DECODE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_DECODE;
      ir_q    <= 5'd0;
      tmo_q   <= 4'd0;
      depth_q <= 4'd0;
    end else begin
      case (state_q)
        S_DECODE: begin
          ir_q    <= opcode;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          tmo_q <= 4'd0;
          if (is_mem)         state_q <= S_MEM;
          else if (stk_fault) state_q <= S_FAULT;
          else                state_q <= exit_state;
        end
        S_MEM: begin
          if (mem_ack)                state_q <= exit_state;
          else if (tmo_q == TMO_LAST) state_q <= S_FAULT;
          else                        tmo_q   <= tmo_q + 4'd1;
        end
        S_HALTED: if (resume) state_q <= S_DECODE;
        S_FAULT:  state_q <= S_FAULT;
        default:  state_q <= S_DECODE;
      endcase
      if (retire && is_jsr)      depth_q <= depth_q + 4'd1;
      else if (retire && is_ret) depth_q <= depth_q - 4'd1;
    end
  end

  // Selects follow IR continuously; strobes only in the retire cycle.
  always_comb begin
    pc_en         = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    write_c       = 1'b0;
    write_z       = 1'b0;
    alu_op        = 3'b000;
    pc_mux        = 2'b00;
    reg_write_mux = 2'b00;
    alu_use_carry = 1'b0;
    alu_in_mux    = 1'b0;
    reg_B_mux     = 1'b0;
    select_c      = 1'b0;
    select_z      = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    stack_depth   = 4'd0;
    if (reset) begin
      if (is_alu) begin
        alu_op        = ir_q[2:0];
        alu_use_carry = (ir_q[2:0] == 3'b001) || (ir_q[2:0] == 3'b011);
      end
      alu_in_mux = is_imm | is_mem;
      reg_B_mux  = is_store;
      select_c   = is_shift;
      select_z   = is_shift;
      if (is_shift)     reg_write_mux = 2'b01;
      else if (is_load) reg_write_mux = 2'b10;
      if (is_branch)             pc_mux = br_taken ? 2'b01 : 2'b00;
      else if (is_jmp || is_jsr) pc_mux = 2'b10;
      else if (is_ret)           pc_mux = 2'b11;
      mem_req   = (state_q == S_MEM);
      mem_write = (state_q == S_MEM) && is_store;
      if (retire) begin
        pc_en     = ~is_halt;
        reg_write = is_alu | is_shift | is_load;
        write_c   = is_alu | is_shift;
        write_z   = is_alu | is_shift;
        push      = is_jsr;
        pop       = is_ret;
      end
      halted      = (state_q == S_HALTED);
      fault       = (state_q == S_FAULT);
      stack_depth = depth_q;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized instruction
// streams checked against an instruction-level reference model.
module tb_cpu_sequencer;

  localparam int STACK_D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       c_flag, z_flag, mem_ack, halt_req, resume;
  logic       pc_en, mem_req, mem_write, reg_write, push, pop;
  logic [2:0] alu_op;
  logic [1:0] pc_mux, reg_write_mux;
  logic       alu_use_carry, alu_in_mux, reg_B_mux, select_c, select_z;
  logic       write_c, write_z, halted, fault;
  logic [3:0] stack_depth;

  int checks = 0;
  int failures = 0;
  int m_depth = 0;

  cpu_sequencer #(.STACK_DEPTH(STACK_D), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .c_flag(c_flag), .z_flag(z_flag),
    .mem_ack(mem_ack), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .mem_req(mem_req), .mem_write(mem_write), .reg_write(reg_write),
    .push(push), .pop(pop), .alu_op(alu_op), .pc_mux(pc_mux),
    .reg_write_mux(reg_write_mux), .alu_use_carry(alu_use_carry),
    .alu_in_mux(alu_in_mux), .reg_B_mux(reg_B_mux), .select_c(select_c),
    .select_z(select_z), .write_c(write_c), .write_z(write_z),
    .halted(halted), .fault(fault), .stack_depth(stack_depth)
  );

  always #5 clk = ~clk;

  wire [7:0]  strb = {pc_en, mem_req, mem_write, reg_write, push, pop, write_c, write_z};
  wire [11:0] sel  = {alu_op, pc_mux, reg_write_mux, alu_use_carry, alu_in_mux,
                      reg_B_mux, select_c, select_z};
  wire [25:0] all_out = {strb, sel, halted, fault, stack_depth};

  // Reference: expected selects for an opcode, from its numeric class.
  function automatic logic [11:0] ref_sel(int op, bit c, bit z);
    logic [2:0] aop = 0;
    logic [1:0] pm = 0, rwm = 0;
    bit uc = 0, im = 0, bm = 0, sh = 0, taken;
    if (op < 16) begin
      aop = 3'(op % 8);
      uc  = (op % 8 == 1) || (op % 8 == 3);
      im  = (op >= 8);
    end else if (op == 16 || op == 17) begin
      im  = 1;
      rwm = (op == 16) ? 2'd2 : 2'd0;
      bm  = (op == 17);
    end else if (op >= 20 && op <= 23) begin
      case (op - 20)
        0: taken = z;
        1: taken = !z;
        2: taken = c;
        default: taken = !c;
      endcase
      pm = taken ? 2'd1 : 2'd0;
    end else if (op >= 24 && op <= 27) begin
      rwm = 2'd1;
      sh  = 1;
    end else if (op == 28 || op == 29) pm = 2'd2;
    else if (op == 30) pm = 2'd3;
    return {aop, pm, rwm, uc, im, bm, sh, sh};
  endfunction

  // Reference: strobes in the retire cycle {pc_en,mem_req,mem_write,reg_write,push,pop,wc,wz}.
  function automatic logic [7:0] ref_strb(int op);
    bit alu_like = (op < 16) || (op >= 24 && op <= 27);
    return {op != 31, op == 16 || op == 17, op == 17, alu_like || op == 16,
            op == 29, op == 30, alu_like, alu_like};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    opcode = 5'd0; c_flag = 0; z_flag = 0; mem_ack = 0; halt_req = 0; resume = 0;
    tick();
    reset = 1'b1;
    m_depth = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opcode = 5'($urandom); c_flag = 1'($urandom); z_flag = 1'($urandom);
      mem_ack = 1'($urandom); halt_req = 1'($urandom); resume = 1'($urandom);
      @(negedge clk);
      checks++;
      if (all_out !== 26'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, all_out);
      end
      tick();
    end
    reset = 1'b1; halt_req = 0; resume = 0; mem_ack = 0;
    @(negedge clk);
    checks++;
    if (all_out !== 26'd0) begin
      failures++;
      $display("FAIL reset_first_decode got=%h want=0", all_out);
    end
    tick();
    do_reset();
  endtask

  task automatic test_alu_imm();
    do_reset();
    opcode = 5'b01001;
    @(negedge clk);
    checks++;
    if (strb !== 8'd0) begin
      failures++; $display("FAIL imm_decode_quiet got=%b want=0", strb);
    end
    tick();
    opcode = 5'd0;
    @(negedge clk);
    checks++;
    if ({pc_en, reg_write, write_c, write_z, mem_req, push, pop} !== 7'b1111000) begin
      failures++; $display("FAIL imm_strobes got=%b want=1111000",
                           {pc_en, reg_write, write_c, write_z, mem_req, push, pop});
    end
    checks++;
    if ({alu_in_mux, alu_use_carry, alu_op, reg_write_mux} !== 7'b1100100) begin
      failures++; $display("FAIL imm_selects got=%b want=1100100",
                           {alu_in_mux, alu_use_carry, alu_op, reg_write_mux});
    end
    tick();
    @(negedge clk);
    checks++;
    if (strb !== 8'd0) begin
      failures++; $display("FAIL imm_single_pulse got=%b want=0", strb);
    end
    tick();
  endtask

  task automatic test_load_ack3();
    int mreq = 0, rw = 0, rw_at = -1;
    logic [1:0] rwm_seen = 2'b00;
    do_reset();
    opcode = 5'b10000;
    tick();
    opcode = 5'b10010;
    for (int k = 0; k < 10; k++) begin
      mem_ack = (k == 3);
      @(negedge clk);
      if (mem_req) mreq++;
      if (reg_write) begin rw++; rw_at = k; rwm_seen = reg_write_mux; end
      tick();
    end
    mem_ack = 0;
    checks++;
    if (mreq != 3) begin failures++; $display("FAIL load_mem_req_cycles got=%0d want=3", mreq); end
    checks++;
    if (rw != 1 || rw_at != 3) begin
      failures++; $display("FAIL load_reg_write got=%0d at=%0d want=1 at=3", rw, rw_at);
    end
    checks++;
    if (rwm_seen !== 2'b10) begin
      failures++; $display("FAIL load_reg_write_mux got=%b want=10", rwm_seen);
    end
  endtask

  task automatic test_store_timeout();
    int mreq = 0, mw = 0, pce = 0;
    bit seen = 0;
    do_reset();
    opcode = 5'b10001;
    tick();
    for (int k = 0; k < 40 && !seen; k++) begin
      mem_ack = 0;
      @(negedge clk);
      if (fault) seen = 1;
      else begin
        if (mem_req) mreq++;
        if (mem_write) mw++;
        if (pc_en) pce++;
        tick();
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL store_timeout_fault got=0 want=1 within 40 cycles"); end
    checks++;
    if (mreq != 16 || mw != 16 || pce != 0) begin
      failures++; $display("FAIL store_timeout_counts mem_req=%0d mem_write=%0d pc_en=%0d want=16,16,0",
                           mreq, mw, pce);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'($urandom); resume = 1'($urandom); halt_req = 1'($urandom);
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || halted !== 1'b0 || strb !== 8'd0) begin
        failures++; $display("FAIL fault_hold fault=%b halted=%b strb=%b want=1,0,0",
                             fault, halted, strb);
      end
      tick();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL fault_cleared got=%b want=0", fault); end
    tick();
  endtask

  task automatic test_jsr_overflow();
    int pushes = 0, pces = 0;
    bit pm_ok = 1;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      opcode = 5'b11101;
      tick();
      @(negedge clk);
      if (push) pushes++;
      if (pc_en) pces++;
      if (push && pc_mux !== 2'b10) pm_ok = 0;
      tick();
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || stack_depth !== 4'd8) begin
      failures++; $display("FAIL jsr_overflow fault=%b depth=%0d want=1,8", fault, stack_depth);
    end
    checks++;
    if (pushes != 8 || pces != 8 || !pm_ok) begin
      failures++; $display("FAIL jsr_pushes push=%0d pc_en=%0d pcmux_ok=%0d want=8,8,1",
                           pushes, pces, pm_ok);
    end
    tick();
  endtask

  task automatic test_ret_underflow();
    do_reset();
    opcode = 5'b11110;
    tick();
    @(negedge clk);
    checks++;
    if (strb !== 8'd0) begin failures++; $display("FAIL ret_underflow_strobes got=%b want=0", strb); end
    tick();
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || stack_depth !== 4'd0) begin
      failures++; $display("FAIL ret_underflow fault=%b depth=%0d want=1,0", fault, stack_depth);
    end
    tick();
  endtask

  task automatic test_bnz();
    do_reset();
    opcode = 5'b10101;
    tick();
    z_flag = 0;
    @(negedge clk);
    checks++;
    if (pc_mux !== 2'b01 || pc_en !== 1'b1) begin
      failures++; $display("FAIL bnz_taken pc_mux=%b pc_en=%b want=01,1", pc_mux, pc_en);
    end
    tick();
    tick();
    z_flag = 1;
    @(negedge clk);
    checks++;
    if (pc_mux !== 2'b00 || pc_en !== 1'b1) begin
      failures++; $display("FAIL bnz_not_taken pc_mux=%b pc_en=%b want=00,1", pc_mux, pc_en);
    end
    tick();
  endtask

  task automatic test_halt_resume();
    do_reset();
    opcode = 5'b10010;
    tick();
    halt_req = 1;
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1) begin failures++; $display("FAIL halt_retire pc_en=%b want=1", pc_en); end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || strb !== 8'd0) begin
        failures++; $display("FAIL halted_hold halted=%b strb=%b want=1,0", halted, strb);
      end
      tick();
    end
    resume = 1;
    tick();
    resume = 0; halt_req = 0; opcode = 5'b01001;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || strb !== 8'd0) begin
      failures++; $display("FAIL resume_decode halted=%b strb=%b want=0,0", halted, strb);
    end
    tick();
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1 || alu_in_mux !== 1'b1) begin
      failures++; $display("FAIL resume_exec pc_en=%b alu_in_mux=%b want=1,1", pc_en, alu_in_mux);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    do_reset();
    opcode = 5'b10000;
    tick();
    tick();
    tick();
    reset = 0; mem_ack = 1;
    @(negedge clk);
    checks++;
    if (all_out !== 26'd0) begin failures++; $display("FAIL reset_abort_mem got=%h want=0", all_out); end
    tick();
    reset = 1; mem_ack = 0; opcode = 5'b10010;
    tick();
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1 || reg_write !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_abort_restart pc_en=%b reg_write=%b mem_req=%b want=1,0,0",
                           pc_en, reg_write, mem_req);
    end
    tick();
  endtask

  task automatic test_random();
    int op, d;
    bit hr, pend_halt;
    logic [7:0] exp;
    do_reset();
    pend_halt = 0;
    for (int n = 0; n <= 150; n++) begin
      if (pend_halt) begin
        resume = 0; halt_req = 1'($urandom);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || strb !== 8'd0) begin
          failures++; $display("FAIL rnd_halted n=%0d halted=%b strb=%b want=1,0", n, halted, strb);
        end
        tick();
        resume = 1;
        tick();
        resume = 0;
      end
      if (n == 150) break;
      op = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) op = $urandom_range(0, 1) ? 29 : 30;
      if ((op == 29 && m_depth == STACK_D) || (op == 30 && m_depth == 0)) op = 28;
      opcode = 5'(op); c_flag = 1'($urandom); z_flag = 1'($urandom);
      halt_req = ($urandom_range(0, 7) == 0); mem_ack = 1'($urandom);
      @(negedge clk);
      checks++;
      if (strb !== 8'd0 || halted !== 1'b0 || fault !== 1'b0 || stack_depth !== 4'(m_depth)) begin
        failures++; $display("FAIL rnd_decode n=%0d strb=%b halted=%b fault=%b depth=%0d want depth=%0d",
                             n, strb, halted, fault, stack_depth, m_depth);
      end
      tick();
      opcode = 5'($urandom); c_flag = 1'($urandom); z_flag = 1'($urandom);
      hr = ($urandom_range(0, 7) == 0); halt_req = hr; mem_ack = 1'($urandom);
      @(negedge clk);
      if (op == 16 || op == 17) begin
        checks++;
        if (strb !== 8'd0 || sel !== ref_sel(op, c_flag, z_flag)) begin
          failures++; $display("FAIL rnd_mem_exec op=%0d strb=%b sel=%b want strb=0 sel=%b",
                               op, strb, sel, ref_sel(op, c_flag, z_flag));
        end
        tick();
        d = $urandom_range(1, 6);
        for (int k = 1; k <= d; k++) begin
          mem_ack = (k == d); hr = ($urandom_range(0, 7) == 0); halt_req = hr;
          c_flag = 1'($urandom); z_flag = 1'($urandom);
          @(negedge clk);
          exp = (k == d) ? ref_strb(op) : {1'b0, 1'b1, op == 17, 5'b0};
          checks++;
          if (strb !== exp || sel !== ref_sel(op, c_flag, z_flag)) begin
            failures++; $display("FAIL rnd_mem op=%0d k=%0d/%0d strb=%b want=%b sel=%b want=%b",
                                 op, k, d, strb, exp, sel, ref_sel(op, c_flag, z_flag));
          end
          tick();
        end
      end else begin
        checks++;
        if (strb !== ref_strb(op) || sel !== ref_sel(op, c_flag, z_flag)) begin
          failures++; $display("FAIL rnd_retire op=%0d strb=%b want=%b sel=%b want=%b",
                               op, strb, ref_strb(op), sel, ref_sel(op, c_flag, z_flag));
        end
        if (op == 29) m_depth++;
        if (op == 30) m_depth--;
        tick();
      end
      mem_ack = 0;
      pend_halt = hr || (op == 31);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    opcode = 5'd0; c_flag = 0; z_flag = 0; mem_ack = 0; halt_req = 0; resume = 0;
    test_reset();
    test_alu_imm();
    test_load_ack3();
    test_store_timeout();
    test_jsr_overflow();
    test_ret_underflow();
    test_bnz();
    test_halt_resume();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 8, SHALL set the return-stack entries tracked.
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of MEM cycles waited for mem_ack.
REQ-003 Port clk, input, 1 bit, SHALL be the clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-low reset.
REQ-005 Port opcode, input, 5 bits, SHALL carry instruction[18:14].
REQ-006 Ports c_flag and z_flag, input, 1 bit each, SHALL carry the datapath C and Z flags.
REQ-007 Port mem_ack, input, 1 bit, SHALL signal completion of a data-memory access.
REQ-008 Ports halt_req and resume, input, 1 bit each, SHALL provide debug halt and resume requests.
REQ-009 Ports pc_en, mem_req, mem_write, reg_write, push and pop, output, 1 bit each, SHALL be the enables and strobes.
REQ-010 Ports alu_op (3 bits), pc_mux (2 bits) and reg_write_mux (2 bits), output, SHALL be the datapath selects.
REQ-011 Ports alu_use_carry, alu_in_mux, reg_B_mux, select_c, select_z, write_c and write_z, output, 1 bit each, SHALL be the datapath controls.
REQ-012 Ports halted, fault (1 bit each) and stack_depth (4 bits), output, SHALL report status.

Function
REQ-013 Decode SHALL be: 00xxx ALU-reg; 01xxx ALU-imm; 110xx shift; 10000 LOAD; 10001 STORE; 1001x NOP; 101cc branch, with cc 00 BZ, 01 BNZ, 10 BC, 11 BNC; 11100 JMP; 11101 JSR; 11110 RET; 11111 HALT.
REQ-014 The FSM SHALL have the states DECODE, EXEC, MEM, HALTED and FAULT.
REQ-015 DECODE SHALL latch opcode into an internal IR, assert no strobes, and go to EXEC.
REQ-016 EXEC SHALL go to MEM for LOAD/STORE; otherwise it retires and goes to DECODE, or to HALTED if halt_req is 1 or the opcode is HALT.
REQ-017 MEM SHALL assert mem_req, plus mem_write for STORE, every cycle until mem_ack; the mem_ack cycle retires and exits as EXEC does.
REQ-018 A 4-bit counter SHALL count MEM cycles without mem_ack; reaching ACK_TIMEOUT SHALL enter FAULT.
REQ-019 pc_en, reg_write, write_c, write_z, push and pop SHALL be asserted only in the retire cycle, and for exactly one cycle per instruction.
REQ-020 In the retire cycle, pc_en SHALL be 1 for every opcode except HALT.
REQ-021 ALU-reg/imm SHALL drive alu_op = IR[2:0], reg_write_mux = 00 and select_c/select_z = 0; alu_in_mux SHALL be 1 for imm only; reg_write, write_c and write_z SHALL be 1.
REQ-022 alu_use_carry SHALL be 1 iff an ALU instruction has alu_op 001 or 011.
REQ-023 Shift SHALL drive reg_write_mux = 01 and select_c = select_z = 1, and SHALL assert reg_write, write_c and write_z.
REQ-024 LOAD/STORE SHALL drive alu_op = 000 and alu_in_mux = 1.
REQ-025 LOAD SHALL drive reg_write_mux = 10 and assert reg_write on ack.
REQ-026 STORE SHALL drive reg_B_mux = 1 and no reg_write.
REQ-027 A branch SHALL drive pc_mux = 01 if taken, else 00, evaluated from c_flag/z_flag in the retire cycle.
REQ-028 JMP SHALL drive pc_mux = 10; JSR SHALL drive pc_mux = 10 with push; RET SHALL drive pc_mux = 11 with pop; all other opcodes SHALL drive pc_mux = 00.
REQ-029 stack_depth SHALL increment on push, decrement on pop, and stay within 0..STACK_DEPTH.
REQ-030 JSR at depth STACK_DEPTH, or RET at depth 0, SHALL enter FAULT without any strobe and without pc_en.
REQ-031 FAULT SHALL hold fault = 1 with all strobes and pc_en at 0 until reset.
REQ-032 HALTED SHALL hold halted = 1 with all strobes at 0; resume = 1 SHALL go to DECODE even if halt_req = 1.
REQ-033 Outside the retire cycle, all write and strobe outputs SHALL be 0 and selects SHALL hold their decoded values.

Reset
REQ-034 When reset = 0 at a clock edge, the state SHALL become DECODE and IR, the timeout counter and stack_depth SHALL become 0.
REQ-035 During reset, every output, including halted and fault, SHALL be 0.
REQ-036 Reset SHALL take priority in every state, aborting MEM mid-access with no retire.

Verification
REQ-037 Scenario: ALU-imm opcode 01001 -> retire in the 2nd cycle after DECODE with pc_en = reg_write = write_c = write_z = 1, alu_in_mux = 1, alu_use_carry = 1.
REQ-038 Scenario: LOAD with mem_ack after 3 MEM cycles -> mem_req high for 3 cycles, then exactly one reg_write with reg_write_mux = 10.
REQ-039 Scenario: STORE with mem_ack held at 0 -> fault = 1 after 16 MEM cycles, and no pc_en at any point.
REQ-040 Scenario: 8 consecutive JSR, then a 9th -> stack_depth = 8, fault = 1, and 8 push pulses total.
REQ-041 Scenario: BNZ with z_flag = 0, then BNZ with z_flag = 1 -> pc_mux = 01, then 00.
REQ-042 Scenario: halt_req asserted during EXEC, then resume -> halted = 1 after retire, then DECODE the cycle after resume.
